// File: rtl/systolic_skew_feeder.sv
// Operand sequencer for a LANES x LANES systolic array: fetches K columns/rows,
// applies the diagonal lane skew with zero fill, and reports completion.
module systolic_skew_feeder #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int LEN_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    output logic                    busy,
    output logic                    done,
    output logic                    clear_acc,
    output logic                    rd_en,
    output logic [LEN_W-1:0]        rd_addr,
    input  logic [LANES*DATA_W-1:0] a_col,
    input  logic [LANES*DATA_W-1:0] b_row,
    output logic [LANES*DATA_W-1:0] out_a,
    output logic [LANES*DATA_W-1:0] out_b,
    output logic                    out_valid
);

    localparam int CNT_W = LEN_W + 1;
    localparam logic [CNT_W-1:0] VALID_TAIL = CNT_W'(2 * (LANES - 1));
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2 * LANES - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   k_ext;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               clear_q, clear_d;
    logic               rd_en_q, rd_en_d;
    logic [LEN_W-1:0]   rd_addr_q, rd_addr_d;
    logic               out_valid_q, out_valid_d;
    logic               data_vld_q, data_vld_d;

    assign k_ext = {1'b0, k_q};

    // cnt_q counts cycles since the first read beat; all timing derives from it.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        clear_d     = 1'b0;
        rd_en_d     = 1'b0;
        rd_addr_d   = '0;
        out_valid_d = 1'b0;
        data_vld_d  = rd_en_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    if (len != '0) begin
                        state_d = FETCH;
                        k_d     = len;
                        busy_d  = 1'b1;
                        clear_d = 1'b1;
                        rd_en_d = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            FETCH: begin
                cnt_d       = cnt_q + 1'b1;
                busy_d      = 1'b1;
                out_valid_d = (cnt_q != '0);
                if (cnt_q == k_ext - 1'b1) begin
                    state_d = DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = cnt_q[LEN_W-1:0] + LEN_W'(1);
                end
            end
            DRAIN: begin
                cnt_d       = cnt_q + 1'b1;
                out_valid_d = (cnt_q <= k_ext + VALID_TAIL);
                if (cnt_q == k_ext + DRAIN_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            clear_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
            data_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            clear_q     <= clear_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            out_valid_q <= out_valid_d;
            data_vld_q  <= data_vld_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign clear_acc = clear_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign out_valid = out_valid_q;

    // Lane i: one gated capture register plus i delay registers; zeros flow in
    // whenever memory data is not valid, so stale or undefined data never leaks.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_W-1:0] a_sk_q [0:i];
        logic [DATA_W-1:0] a_sk_d [0:i];
        logic [DATA_W-1:0] b_sk_q [0:i];
        logic [DATA_W-1:0] b_sk_d [0:i];

        always_comb begin
            a_sk_d[0] = data_vld_q ? a_col[i*DATA_W +: DATA_W] : '0;
            b_sk_d[0] = data_vld_q ? b_row[i*DATA_W +: DATA_W] : '0;
            for (int s = 1; s <= i; s++) begin
                a_sk_d[s] = a_sk_q[s-1];
                b_sk_d[s] = b_sk_q[s-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s <= i; s++) begin
                    a_sk_q[s] <= '0;
                    b_sk_q[s] <= '0;
                end
            end else begin
                for (int s = 0; s <= i; s++) begin
                    a_sk_q[s] <= a_sk_d[s];
                    b_sk_q[s] <= b_sk_d[s];
                end
            end
        end

        assign out_a[i*DATA_W +: DATA_W] = a_sk_q[i];
        assign out_b[i*DATA_W +: DATA_W] = b_sk_q[i];
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with a 1-cycle-latency memory model.
module tb_systolic_skew_feeder;

    localparam int DATA_W = 16;
    localparam int LANES  = 4;
    localparam int LEN_W  = 8;
    localparam int W      = LANES * DATA_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy, done, clear_acc, rd_en, out_valid;
    logic [LEN_W-1:0] rd_addr;
    logic [W-1:0]     a_col, b_row, out_a, out_b;

    logic [W-1:0] mem_a [0:255];
    logic [W-1:0] mem_b [0:255];

    int vectors     = 0;
    int miscompares = 0;

    systolic_skew_feeder #(.DATA_W(DATA_W), .LANES(LANES), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .busy(busy), .done(done), .clear_acc(clear_acc),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .a_col(a_col), .b_row(b_row),
        .out_a(out_a), .out_b(out_b), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Memory returns junk when not read so any missing zero gating is visible.
    always @(posedge clk) begin
        a_col <= rd_en ? mem_a[rd_addr] : {4{16'hDEAD}};
        b_row <= rd_en ? mem_b[rd_addr] : {4{16'hBEEF}};
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " out_a"}, out_a, '0);
        chk({tag, " out_b"}, out_b, '0);
        chk({tag, " ctrl"}, W'({busy, done, clear_acc, rd_en, out_valid}), '0);
        chk({tag, " rd_addr"}, W'(rd_addr), '0);
    endtask

    function automatic logic [W-1:0] exp_out(input bit sel_b, input int k_len, input int rel);
        logic [W-1:0] r;
        logic [W-1:0] w;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            int k;
            k = rel - 3 - i;
            if (k >= 0 && k < k_len) begin
                w = sel_b ? mem_b[k] : mem_a[k];
                r[i*DATA_W +: DATA_W] = w[i*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    // One run: start in the current cycle (T), then check cycles T+1.. onward.
    task automatic run(input string tag, input int k_len, input int extra_rel);
        int last;
        last  = (k_len == 0) ? 2 : k_len + 10;
        len   = LEN_W'(k_len);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        len   = LEN_W'($urandom);
        for (int rel = 1; rel <= last; rel++) begin
            bit kp;
            kp = (k_len > 0);
            chk($sformatf("%s busy@%0d", tag, rel), W'(busy), W'(kp && rel <= k_len + 8));
            chk($sformatf("%s done@%0d", tag, rel), W'(done), W'(kp ? rel == k_len + 9 : rel == 1));
            chk($sformatf("%s clear@%0d", tag, rel), W'(clear_acc), W'(kp && rel == 1));
            chk($sformatf("%s rd_en@%0d", tag, rel), W'(rd_en), W'(kp && rel <= k_len));
            if (kp && rel <= k_len)
                chk($sformatf("%s rd_addr@%0d", tag, rel), W'(rd_addr), W'(rel - 1));
            chk($sformatf("%s valid@%0d", tag, rel), W'(out_valid),
                W'(kp && rel >= 3 && rel <= k_len + 8));
            chk($sformatf("%s out_a@%0d", tag, rel), out_a, exp_out(1'b0, k_len, rel));
            chk($sformatf("%s out_b@%0d", tag, rel), out_b, exp_out(1'b1, k_len, rel));
            start = (rel == extra_rel);
            if (rel < last) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        len   = '0;
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = '0;
            mem_b[k] = '0;
        end

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1 chk_idle("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk_idle("post_reset_idle");
        end

        // Identity matrices.
        for (int k = 0; k < 4; k++) begin
            mem_a[k] = W'(1) << (k * DATA_W);
            mem_b[k] = W'(1) << (k * DATA_W);
        end
        run("ident", 4, 0);

        // Constant-per-column data on all lanes.
        for (int k = 0; k < 4; k++) begin
            mem_a[k] = {4{16'(k + 1)}};
            mem_b[k] = {4{16'(k + 5)}};
        end
        run("ramp", 4, 0);

        // Zero-length request.
        run("k0", 0, 0);

        // Start during the run and during DONE is ignored; then back-to-back run.
        run("busy_start", 4, 5);
        run("done_start", 4, 13);
        for (int k = 0; k < 7; k++) begin
            mem_a[k] = {$urandom, $urandom};
            mem_b[k] = {$urandom, $urandom};
        end
        run("b2b_k7", 7, 0);
        run("k1", 1, 0);

        // Reset in the middle of a K=8 run.
        len   = 8'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
        end
        #1 rst = 1'b1;
        #1 chk_idle("midrun_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            chk($sformatf("abort_no_done@%0d", c), W'({done, busy, rd_en}), '0);
        end
        for (int k = 0; k < 2; k++) begin
            mem_a[k] = {4{16'(16'h100 + k)}};
            mem_b[k] = {4{16'(16'h200 + k)}};
        end
        run("after_abort_k2", 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
